// File: rtl/rv32i_accel_issue_queue_if.sv
// rtl/rv32i_accel_issue_queue_if.sv - CPU, accelerator and writeback signal bundle for the accelerator issue queue
interface rv32i_accel_issue_queue_if #(
  parameter int CNT_W = 3
);
  logic             cpu_valid;
  logic             cpu_ready;
  logic [31:0]      cpu_instr;
  logic [31:0]      cpu_rs1_val;
  logic [31:0]      cpu_rs2_val;
  logic [4:0]       cpu_rd;
  logic             acc_instr_valid;
  logic             acc_instr_ready;
  logic [31:0]      acc_instr;
  logic [31:0]      acc_rs1_val;
  logic [31:0]      acc_rs2_val;
  logic [4:0]       acc_rd_addr;
  logic             acc_rd_we;
  logic [4:0]       acc_rd_waddr;
  logic [31:0]      acc_rd_wdata;
  logic             wb_we;
  logic [4:0]       wb_waddr;
  logic [31:0]      wb_wdata;
  logic [31:0]      pending_rd;
  logic [CNT_W-1:0] q_count;
  logic             err_illegal;
  logic             err_spurious;

  modport slave (
    input  cpu_valid, cpu_instr, cpu_rs1_val, cpu_rs2_val, cpu_rd,
    input  acc_instr_ready, acc_rd_we, acc_rd_waddr, acc_rd_wdata,
    output cpu_ready, acc_instr_valid, acc_instr, acc_rs1_val, acc_rs2_val, acc_rd_addr,
    output wb_we, wb_waddr, wb_wdata, pending_rd, q_count, err_illegal, err_spurious
  );

  modport master (
    output cpu_valid, cpu_instr, cpu_rs1_val, cpu_rs2_val, cpu_rd,
    output acc_instr_ready, acc_rd_we, acc_rd_waddr, acc_rd_wdata,
    input  cpu_ready, acc_instr_valid, acc_instr, acc_rs1_val, acc_rs2_val, acc_rd_addr,
    input  wb_we, wb_waddr, wb_wdata, pending_rd, q_count, err_illegal, err_spurious
  );
endinterface

// File: rtl/rv32i_accel_issue_queue.sv
// rtl/rv32i_accel_issue_queue.sv - in-order issue FIFO to the MAC accelerator with rd scoreboard and writeback
module rv32i_accel_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                     clk,
  input logic                     rst,
  rv32i_accel_issue_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      rs1_q   [DEPTH];
  logic [31:0]      rs2_q   [DEPTH];
  logic [4:0]       rd_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_waddr_q, wb_waddr_d;
  logic [31:0]      wb_wdata_q, wb_wdata_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_spurious_q, err_spurious_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_accel, is_rdop, full, rd_hazard, cpu_ready, accept, enq, deq;

  always_comb begin
    opcode    = bus.cpu_instr[6:0];
    funct3    = bus.cpu_instr[14:12];
    funct7    = bus.cpu_instr[31:25];
    is_accel  = (opcode == 7'h33) && (funct7 == 7'h01) && (funct3 <= 3'b100);
    is_rdop   = is_accel && ((funct3 == 3'b011) || (funct3 == 3'b100));
    full      = (count_q == FULL_CNT);
    // A second CRD/STAT to a register still awaiting its result would race the writeback.
    rd_hazard = is_rdop && (bus.cpu_rd != 5'd0) && pending_q[bus.cpu_rd];
    cpu_ready = !full && !rd_hazard;
    accept    = bus.cpu_valid && cpu_ready;
    enq       = accept && is_accel;
    deq       = (count_q != '0) && bus.acc_instr_ready;
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end

    pending_d = pending_q;
    if (bus.acc_rd_we) begin
      pending_d[bus.acc_rd_waddr] = 1'b0;
    end
    if (enq && is_rdop && (bus.cpu_rd != 5'd0)) begin
      pending_d[bus.cpu_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    // Address/data only move on a real write so they hold across idle and x0 cycles.
    wb_we_d    = bus.acc_rd_we && (bus.acc_rd_waddr != 5'd0);
    wb_waddr_d = wb_we_d ? bus.acc_rd_waddr : wb_waddr_q;
    wb_wdata_d = wb_we_d ? bus.acc_rd_wdata : wb_wdata_q;

    err_illegal_d  = accept && !is_accel;
    err_spurious_d = bus.acc_rd_we && (bus.acc_rd_waddr != 5'd0) && !pending_q[bus.acc_rd_waddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pending_q      <= '0;
      wb_we_q        <= 1'b0;
      wb_waddr_q     <= '0;
      wb_wdata_q     <= '0;
      err_illegal_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pending_q      <= pending_d;
      wb_we_q        <= wb_we_d;
      wb_waddr_q     <= wb_waddr_d;
      wb_wdata_q     <= wb_wdata_d;
      err_illegal_q  <= err_illegal_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr_q] <= bus.cpu_instr;
      rs1_q[wr_ptr_q]   <= bus.cpu_rs1_val;
      rs2_q[wr_ptr_q]   <= bus.cpu_rs2_val;
      rd_q[wr_ptr_q]    <= bus.cpu_rd;
    end
  end

  assign bus.cpu_ready       = cpu_ready;
  assign bus.acc_instr_valid = (count_q != '0);
  assign bus.acc_instr       = instr_q[rd_ptr_q];
  assign bus.acc_rs1_val     = rs1_q[rd_ptr_q];
  assign bus.acc_rs2_val     = rs2_q[rd_ptr_q];
  assign bus.acc_rd_addr     = rd_q[rd_ptr_q];
  assign bus.wb_we           = wb_we_q;
  assign bus.wb_waddr        = wb_waddr_q;
  assign bus.wb_wdata        = wb_wdata_q;
  assign bus.pending_rd      = pending_q;
  assign bus.q_count         = count_q;
  assign bus.err_illegal     = err_illegal_q;
  assign bus.err_spurious    = err_spurious_q;
endmodule

// File: tb/tb_rv32i_accel_issue_queue.sv
// tb/tb_rv32i_accel_issue_queue.sv - directed and randomized bench for the accelerator issue queue
module tb_rv32i_accel_issue_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_accel_issue_queue_if #(.CNT_W(CNT_W)) bus ();
  rv32i_accel_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpend;
  logic        m_wb_we;
  logic [4:0]  m_wb_waddr;
  logic [31:0] m_wb_wdata;
  logic        m_ill;
  logic        m_spur;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'h01, 5'd3, 5'd2, f3, rd, 7'h33};
  endfunction

  function automatic logic accel_of(input logic [31:0] i);
    return (i[6:0] == 7'h33) && (i[31:25] == 7'h01) && (i[14:12] <= 3'd4);
  endfunction

  function automatic logic rdop_of(input logic [31:0] i);
    return accel_of(i) && ((i[14:12] == 3'd3) || (i[14:12] == 3'd4));
  endfunction

  function automatic logic exp_ready();
    return (mq.size() < DEPTH) &&
           !(rdop_of(bus.cpu_instr) && (bus.cpu_rd != 5'd0) && mpend[bus.cpu_rd]);
  endfunction

  task automatic model_reset();
    mq.delete();
    mpend      = '0;
    m_wb_we    = 1'b0;
    m_wb_waddr = '0;
    m_wb_wdata = '0;
    m_ill      = 1'b0;
    m_spur     = 1'b0;
  endtask

  task automatic check_all();
    chk("cpu_ready", bus.cpu_ready, exp_ready());
    chk("acc_valid", bus.acc_instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("acc_instr", bus.acc_instr, mq[0].instr);
      chk("acc_rs1", bus.acc_rs1_val, mq[0].rs1);
      chk("acc_rs2", bus.acc_rs2_val, mq[0].rs2);
      chk("acc_rd", bus.acc_rd_addr, mq[0].rd);
    end
    chk("q_count", bus.q_count, mq.size());
    chk("pending_rd", bus.pending_rd, mpend);
    chk("wb_we", bus.wb_we, m_wb_we);
    if (m_wb_we) begin
      chk("wb_waddr", bus.wb_waddr, m_wb_waddr);
      chk("wb_wdata", bus.wb_wdata, m_wb_wdata);
    end
    chk("err_illegal", bus.err_illegal, m_ill);
    chk("err_spurious", bus.err_spurious, m_spur);
  endtask

  // Checks at the falling edge, advances the model across the rising edge, returns 1 time unit after it.
  task automatic tick();
    logic fire, acc;
    ent_t e;
    #4;
    check_all();
    fire   = bus.cpu_valid && exp_ready();
    acc    = accel_of(bus.cpu_instr);
    m_ill  = fire && !acc;
    m_spur = bus.acc_rd_we && (bus.acc_rd_waddr != 5'd0) && !mpend[bus.acc_rd_waddr];
    if (bus.acc_rd_we && (bus.acc_rd_waddr != 5'd0)) begin
      m_wb_we    = 1'b1;
      m_wb_waddr = bus.acc_rd_waddr;
      m_wb_wdata = bus.acc_rd_wdata;
    end else begin
      m_wb_we = 1'b0;
    end
    if (bus.acc_rd_we) mpend[bus.acc_rd_waddr] = 1'b0;
    if (fire && rdop_of(bus.cpu_instr) && (bus.cpu_rd != 5'd0)) mpend[bus.cpu_rd] = 1'b1;
    if ((mq.size() != 0) && bus.acc_instr_ready) void'(mq.pop_front());
    if (fire && acc) begin
      e.instr = bus.cpu_instr;
      e.rs1   = bus.cpu_rs1_val;
      e.rs2   = bus.cpu_rs2_val;
      e.rd    = bus.cpu_rd;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    bus.cpu_valid   = 1'b1;
    bus.cpu_instr   = instr;
    bus.cpu_rs1_val = a;
    bus.cpu_rs2_val = b;
    bus.cpu_rd      = rd;
  endtask

  task automatic idle_cpu();
    bus.cpu_valid = 1'b0;
    bus.cpu_instr = '0;
    bus.cpu_rd    = '0;
  endtask

  task automatic result(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.acc_rd_we    = we;
    bus.acc_rd_waddr = a;
    bus.acc_rd_wdata = d;
  endtask

  initial begin
    logic [31:0] t2_instr [4];
    int          pick;
    logic [2:0]  f3;
    logic [4:0]  rd;

    rst = 1'b1;
    idle_cpu();
    bus.cpu_rs1_val     = '0;
    bus.cpu_rs2_val     = '0;
    bus.acc_instr_ready = 1'b0;
    result(1'b0, 5'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_count", bus.q_count, 0);
    chk("rst_pending", bus.pending_rd, 0);
    chk("rst_acc_valid", bus.acc_instr_valid, 0);
    chk("rst_wb_we", bus.wb_we, 0);
    chk("rst_wb_waddr", bus.wb_waddr, 0);
    chk("rst_wb_wdata", bus.wb_wdata, 0);
    chk("rst_err_illegal", bus.err_illegal, 0);
    chk("rst_err_spurious", bus.err_spurious, 0);
    rst = 1'b0;

    // 1) single op visible one cycle after enqueue
    bus.acc_instr_ready = 1'b1;
    present(mk(3'd0, 5'd1), 32'h0000_0013, 32'h3F80_0000, 5'd1);
    tick();
    idle_cpu();
    chk("t1_valid", bus.acc_instr_valid, 1);
    chk("t1_instr", bus.acc_instr, mk(3'd0, 5'd1));
    chk("t1_rs1", bus.acc_rs1_val, 32'h0000_0013);
    chk("t1_rs2", bus.acc_rs2_val, 32'h3F80_0000);
    chk("t1_rd", bus.acc_rd_addr, 1);
    tick();

    // 2) fill with ready low, then drain in order
    bus.acc_instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t2_instr[i] = mk(3'(i % 3), 5'(10 + i));
      present(t2_instr[i], 32'(i * 7), 32'(i * 11), 5'(10 + i));
      tick();
    end
    idle_cpu();
    chk("t2_full_count", bus.q_count, 4);
    chk("t2_full_ready", bus.cpu_ready, 0);
    present(mk(3'd0, 5'd20), 32'd1, 32'd2, 5'd20);
    tick();
    idle_cpu();
    bus.acc_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_count", bus.q_count, 4 - i);
      chk("t2_drain_instr", bus.acc_instr, t2_instr[i]);
      tick();
    end
    chk("t2_empty", bus.q_count, 0);

    // 3) CRD scoreboard interlock
    present(mk(3'd3, 5'd5), 32'h11, 32'h22, 5'd5);
    tick();
    chk("t3_pending", bus.pending_rd, 32'h20);
    tick();
    chk("t3_stall", bus.cpu_ready, 0);
    result(1'b1, 5'd5, 32'h4000_0000);
    tick();
    result(1'b0, 5'd0, 32'd0);
    chk("t3_wb_we", bus.wb_we, 1);
    chk("t3_wb_wdata", bus.wb_wdata, 32'h4000_0000);
    chk("t3_pending_clr", bus.pending_rd, 0);
    chk("t3_unstall", bus.cpu_ready, 1);
    tick();
    idle_cpu();
    chk("t3_reaccept", bus.pending_rd, 32'h20);
    tick();
    result(1'b1, 5'd5, 32'h5);
    tick();
    result(1'b0, 5'd0, 32'd0);
    tick();

    // 4) illegal instructions dropped
    present(32'h0000_0033, 32'd0, 32'd0, 5'd1);
    tick();
    idle_cpu();
    chk("t4_ill_add", bus.err_illegal, 1);
    chk("t4_cnt_add", bus.q_count, 0);
    tick();
    chk("t4_ill_clear", bus.err_illegal, 0);
    present(mk(3'd7, 5'd4), 32'd0, 32'd0, 5'd4);
    tick();
    idle_cpu();
    chk("t4_ill_f3", bus.err_illegal, 1);
    chk("t4_cnt_f3", bus.q_count, 0);
    tick();

    // 5) x0 and spurious writebacks
    result(1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    result(1'b1, 5'd7, 32'h1234_5678);
    chk("t5_x0_we", bus.wb_we, 0);
    chk("t5_x0_spur", bus.err_spurious, 0);
    tick();
    result(1'b0, 5'd0, 32'd0);
    chk("t5_x7_we", bus.wb_we, 1);
    chk("t5_x7_addr", bus.wb_waddr, 7);
    chk("t5_x7_spur", bus.err_spurious, 1);
    tick();

    // 6) asynchronous reset mid-operation
    bus.acc_instr_ready = 1'b0;
    present(mk(3'd3, 5'd9), 32'd1, 32'd2, 5'd9);
    tick();
    present(mk(3'd0, 5'd1), 32'd3, 32'd4, 5'd1);
    tick();
    present(mk(3'd1, 5'd2), 32'd5, 32'd6, 5'd2);
    tick();
    idle_cpu();
    chk("t6_count", bus.q_count, 3);
    chk("t6_pending", bus.pending_rd, 32'h200);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", bus.q_count, 0);
    chk("t6_rst_pending", bus.pending_rd, 0);
    chk("t6_rst_valid", bus.acc_instr_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized traffic against the queue/scoreboard model
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 9));
      f3   = (pick == 1) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rd   = 5'($urandom_range(0, 31));
      present(mk(f3, rd), $urandom, $urandom, rd);
      if (pick == 0) bus.cpu_instr = {$urandom} & 32'hFFFF_FF80 | 32'h13;
      bus.cpu_valid       = ($urandom_range(0, 2) != 0);
      bus.acc_instr_ready = 1'($urandom_range(0, 1));
      result(1'b0, 5'd0, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.acc_rd_we    = 1'b1;
        bus.acc_rd_waddr = 5'($urandom_range(0, 31));
        if ((mpend != 0) && ($urandom_range(0, 3) != 0)) begin
          for (int k = 0; k < 32; k++) begin
            if (mpend[(k + n) % 32]) bus.acc_rd_waddr = 5'((k + n) % 32);
          end
        end
      end
      tick();
    end
    idle_cpu();
    result(1'b0, 5'd0, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
